data_mem_access: RTL



---
 rtl/mem_pkg.sv | 53 +++++
 rtl/store_lane_align.sv | 53 +++++
 rtl/data_mem_access.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory-stage front end: opcode encodings of the
// load/store instructions, big-endian lane offsets, the access FSM state enum
// and small opcode-classification helpers.
// Ports: none (package).
// ---------------------------------------------------------------------------
package mem_pkg;

    // Load opcodes
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;

    // Store opcodes
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    // Big-endian byte offsets: offset 0 is the most significant lane
    localparam logic [1:0] LANE_OFF_0 = 2'b00;  // bits [31:24], WE bit 3
    localparam logic [1:0] LANE_OFF_1 = 2'b01;  // bits [23:16], WE bit 2
    localparam logic [1:0] LANE_OFF_2 = 2'b10;  // bits [15:8],  WE bit 1
    localparam logic [1:0] LANE_OFF_3 = 2'b11;  // bits [7:0],   WE bit 0

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } state_t;

    function automatic logic isLoad(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic isStore(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=00.
    // Byte accesses and non-memory opcodes are never misaligned.
    function automatic logic isMisaligned(input logic [5:0] op, input logic [1:0] off);
        logic half;
        logic word;
        half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
        word = (op == OP_LW) || (op == OP_SW);
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// ---------------------------------------------------------------------------
// store_lane_align
// Combinational big-endian byte-enable generation and store-data lane
// placement for the data memory interface.
// Ports:
//   opcode_i  - instruction opcode
//   offset_i  - byte address bits [1:0]
//   wdata_i   - store source value, right-justified
//   we_o      - byte write enables (bit 3 = bits [31:24]); zero for non-stores
//   wdata_o   - lane-aligned store data
// ---------------------------------------------------------------------------
module store_lane_align
    import mem_pkg::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  we_o,
    output logic [31:0] wdata_o
);

    // Byte and halfword stores replicate the source across all lanes so the
    // memory only needs the enables to pick the right one.
    always_comb begin
        we_o    = 4'b0000;
        wdata_o = wdata_i;
        unique case (opcode_i)
            OP_SB: begin
                unique case (offset_i)
                    LANE_OFF_0: we_o = 4'b1000;
                    LANE_OFF_1: we_o = 4'b0100;
                    LANE_OFF_2: we_o = 4'b0010;
                    LANE_OFF_3: we_o = 4'b0001;
                    default:    we_o = 4'b0000;
                endcase
                wdata_o = {4{wdata_i[7:0]}};
            end
            OP_SH: begin
                we_o    = offset_i[1] ? 4'b0011 : 4'b1100;
                wdata_o = {2{wdata_i[15:0]}};
            end
            OP_SW: begin
                we_o    = 4'b1111;
                wdata_o = wdata_i;
            end
            default: begin
                we_o    = 4'b0000;
                wdata_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_access.sv
// ---------------------------------------------------------------------------
// data_mem_access
// Memory-stage front end: accepts load/store requests from execute, drives a
// valid/ready request to data memory, stalls the pipeline while an access is
// outstanding and registers the returned word for the load masker.
// Ports:
//   Clock, Reset         - rising-edge clock, asynchronous active-low reset
//   ReqValid, opcodeE,
//   ALUoutE, WriteDataE  - instruction presented by the execute stage
//   Stall                - freeze IF/EX while not idle
//   AddrError            - pulse on a misaligned load/store at acceptance
//   MemReqValid/Ready,
//   MemAddr, MemWE,
//   MemWData             - request channel to data memory
//   MemRespValid, MemRData - read response from data memory
//   ReadDataM, opcodeM,
//   ALUoutM, LoadValidM  - registered bundle for the load masker
// ---------------------------------------------------------------------------
module data_mem_access
    import mem_pkg::*;
#(
    parameter int MEM_ADDR_W = 30
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ReqValid,
    input  logic [5:0]            opcodeE,
    input  logic [31:0]           ALUoutE,
    input  logic [31:0]           WriteDataE,
    output logic                  Stall,
    output logic                  AddrError,
    output logic                  MemReqValid,
    input  logic                  MemReqReady,
    output logic [MEM_ADDR_W-1:0] MemAddr,
    output logic [3:0]            MemWE,
    output logic [31:0]           MemWData,
    input  logic                  MemRespValid,
    input  logic [31:0]           MemRData,
    output logic [31:0]           ReadDataM,
    output logic [5:0]            opcodeM,
    output logic [1:0]            ALUoutM,
    output logic                  LoadValidM
);

    state_t                state_q, state_d;
    logic [MEM_ADDR_W-1:0] memAddr_q;
    logic [3:0]            memWe_q;
    logic [31:0]           memWData_q;
    logic                  reqIsLoad_q;
    logic [31:0]           readData_q;
    logic [5:0]            opcodeM_q;
    logic [1:0]            aluOutM_q;
    logic                  loadValid_q;

    logic                  accept;
    logic                  isMemOp;
    logic                  misaligned;
    logic                  startAccess;
    logic                  respTaken;
    logic [3:0]            alignWe;
    logic [31:0]           alignWData;

    store_lane_align u_align (
        .opcode_i (opcodeE),
        .offset_i (ALUoutE[1:0]),
        .wdata_i  (WriteDataE),
        .we_o     (alignWe),
        .wdata_o  (alignWData)
    );

    // Requests are only looked at while idle; anything presented during a
    // stall is held upstream until we come back to IDLE.
    always_comb begin
        accept      = (state_q == IDLE) && ReqValid;
        isMemOp     = isLoad(opcodeE) || isStore(opcodeE);
        misaligned  = isMemOp && isMisaligned(opcodeE, ALUoutE[1:0]);
        startAccess = accept && isMemOp && !misaligned;
        respTaken   = (state_q == WAIT) && MemRespValid;
    end

    // Next-state logic. Stores are posted: once memory takes the request the
    // pipeline may continue, so only loads wait for the response.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (startAccess) state_d = REQ;
            REQ:  if (MemReqReady) state_d = reqIsLoad_q ? WAIT : IDLE;
            WAIT: if (MemRespValid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            memAddr_q   <= '0;
            memWe_q     <= 4'b0000;
            memWData_q  <= 32'h0;
            reqIsLoad_q <= 1'b0;
            readData_q  <= 32'h0;
            opcodeM_q   <= 6'b000000;
            aluOutM_q   <= 2'b00;
            loadValid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            loadValid_q <= respTaken;
            // Request fields are captured once so they stay stable through
            // any amount of memory backpressure.
            if (startAccess) begin
                memAddr_q   <= ALUoutE[MEM_ADDR_W+1:2];
                memWe_q     <= alignWe;
                memWData_q  <= alignWData;
                reqIsLoad_q <= isLoad(opcodeE);
            end
            // Misaligned and non-memory ops still advance opcode/offset so
            // the load masker sees every accepted instruction.
            if (accept) begin
                opcodeM_q <= opcodeE;
                aluOutM_q <= ALUoutE[1:0];
            end
            if (respTaken) begin
                readData_q <= MemRData;
            end
        end
    end

    assign Stall       = (state_q != IDLE);
    assign MemReqValid = (state_q == REQ);
    assign AddrError   = accept && misaligned;
    assign MemAddr     = memAddr_q;
    assign MemWE       = memWe_q;
    assign MemWData    = memWData_q;
    assign ReadDataM   = readData_q;
    assign opcodeM     = opcodeM_q;
    assign ALUoutM     = aluOutM_q;
    assign LoadValidM  = loadValid_q;

endmodule
